// File: rtl/haar_db_pkg.sv
// Shared constants for the Haar stage database reader: database size derivation,
// word-kind encoding and the read sequencer state encoding.
package haar_db_pkg;

    localparam int DEF_NUM_CLASSIFIERS          = 10;
    localparam int DEF_NUM_PARAM_PER_CLASSIFIER = 19;
    localparam int DEF_NUM_STAGE_THRESHOLD      = 3;

    function automatic int num_database_index(input int n_cls, input int n_param, input int n_thr);
        return n_cls * n_param + n_thr;
    endfunction

    localparam int NUM_DATABASE_INDEX = num_database_index(DEF_NUM_CLASSIFIERS,
                                                           DEF_NUM_PARAM_PER_CLASSIFIER,
                                                           DEF_NUM_STAGE_THRESHOLD);

    localparam logic KIND_PARAM     = 1'b0;
    localparam logic KIND_THRESHOLD = 1'b1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_CAPTURE,
        S_HOLD,
        S_DONE
    } state_e;

endpackage

// File: rtl/stage_database_reader_if.sv
// Tagged parameter stream from the stage database reader to the classifier engine.
interface stage_database_reader_if #(
    parameter int DATA_WIDTH = 16
);
    logic                  param_valid;
    logic                  param_ready;
    logic [DATA_WIDTH-1:0] param_data;
    logic                  param_kind;
    logic [3:0]            classifier_idx;
    logic [4:0]            param_idx;
    logic                  param_last;

    modport master (
        output param_valid, param_data, param_kind, classifier_idx, param_idx, param_last,
        input  param_ready
    );

    modport slave (
        input  param_valid, param_data, param_kind, classifier_idx, param_idx, param_last,
        output param_ready
    );
endinterface

// File: rtl/stage_param_index_tracker.sv
// Tracks which classifier record / threshold word the current database address belongs
// to, using wrapping counters so no divider is needed.
module stage_param_index_tracker
    import haar_db_pkg::*;
#(
    parameter int NUM_CLASSIFIERS          = DEF_NUM_CLASSIFIERS,
    parameter int NUM_PARAM_PER_CLASSIFIER = DEF_NUM_PARAM_PER_CLASSIFIER,
    parameter int NUM_STAGE_THRESHOLD      = DEF_NUM_STAGE_THRESHOLD
) (
    input  logic       clk_fpga,
    input  logic       reset_fpga,
    input  logic       clear_i,
    input  logic       advance_i,
    output logic [3:0] classifier_idx_o,
    output logic [4:0] param_idx_o,
    output logic       kind_o,
    output logic       last_o
);

    localparam logic [4:0] PARAM_MAX = 5'(NUM_PARAM_PER_CLASSIFIER - 1);
    localparam logic [4:0] THR_MAX   = 5'(NUM_STAGE_THRESHOLD - 1);
    localparam logic [3:0] CLS_MAX   = 4'(NUM_CLASSIFIERS - 1);

    logic [4:0] param_q, param_d;
    logic [3:0] cls_q, cls_d;
    logic       kind_q, kind_d;

    always_comb begin
        // NOTE: every _d gets its hold value first so no branch can infer a latch.
        param_d = param_q;
        cls_d   = cls_q;
        kind_d  = kind_q;
        if (clear_i) begin
            param_d = '0;
            cls_d   = '0;
            kind_d  = KIND_PARAM;
        end else if (advance_i) begin
            if (kind_q == KIND_PARAM && param_q == PARAM_MAX) begin
                param_d = '0;
                if (cls_q == CLS_MAX) begin
                    cls_d  = '0;
                    kind_d = KIND_THRESHOLD;
                end else begin
                    cls_d = cls_q + 4'd1;
                end
            end else begin
                param_d = param_q + 5'd1;
            end
        end
    end

    always_ff @(posedge clk_fpga or posedge reset_fpga) begin
        if (reset_fpga) begin
            param_q <= '0;
            cls_q   <= '0;
            kind_q  <= KIND_PARAM;
        end else begin
            param_q <= param_d;
            cls_q   <= cls_d;
            kind_q  <= kind_d;
        end
    end

    assign classifier_idx_o = cls_q;
    assign param_idx_o      = param_q;
    assign kind_o           = kind_q;
    assign last_o           = (kind_q == KIND_PARAM) ? (param_q == PARAM_MAX) : (param_q == THR_MAX);

endmodule

// File: rtl/stage_database_reader.sv
// Walks the whole stage database once per start request through a 1-cycle read port and
// streams each word, tagged with its record position, over a valid/ready handshake.
module stage_database_reader
    import haar_db_pkg::*;
#(
    parameter int ADDR_WIDTH               = 10,
    parameter int DATA_WIDTH_16            = 16,
    parameter int NUM_CLASSIFIERS          = DEF_NUM_CLASSIFIERS,
    parameter int NUM_PARAM_PER_CLASSIFIER = DEF_NUM_PARAM_PER_CLASSIFIER,
    parameter int NUM_STAGE_THRESHOLD      = DEF_NUM_STAGE_THRESHOLD
) (
    input  logic                     clk_fpga,
    input  logic                     reset_fpga,
    input  logic                     i_db_ready,
    input  logic                     i_start,
    output logic                     o_busy,
    output logic                     o_rd_en,
    output logic [ADDR_WIDTH-1:0]    o_rd_addr,
    input  logic [DATA_WIDTH_16-1:0] i_rd_data,
    stage_database_reader_if.master  param_if,
    output logic                     o_done,
    output logic                     o_abort
);

    localparam int DB_WORDS = num_database_index(NUM_CLASSIFIERS, NUM_PARAM_PER_CLASSIFIER,
                                                 NUM_STAGE_THRESHOLD);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DB_WORDS - 1);

    if (DB_WORDS > (2 ** ADDR_WIDTH)) begin : g_bad_addr_width
        $error("stage_database_reader: database does not fit in ADDR_WIDTH address space");
    end

    state_e                   state_q;
    logic                     busy_q, rd_en_q, valid_q, done_q, abort_q;
    logic [ADDR_WIDTH-1:0]    addr_q;
    logic [DATA_WIDTH_16-1:0] data_q;
    logic                     kind_q, last_q;
    logic [3:0]               cls_q;
    logic [4:0]               pidx_q;

    logic       start_ok, abort_now, accept, trk_clear;
    logic [3:0] trk_cls;
    logic [4:0] trk_pidx;
    logic       trk_kind, trk_last;

    assign start_ok  = (state_q == S_IDLE) && i_start && i_db_ready;
    assign abort_now = (state_q != S_IDLE) && !i_db_ready;
    assign accept    = (state_q == S_HOLD) && param_if.param_ready && i_db_ready;
    assign trk_clear = start_ok || abort_now || (state_q == S_DONE);

    stage_param_index_tracker #(
        .NUM_CLASSIFIERS          (NUM_CLASSIFIERS),
        .NUM_PARAM_PER_CLASSIFIER (NUM_PARAM_PER_CLASSIFIER),
        .NUM_STAGE_THRESHOLD      (NUM_STAGE_THRESHOLD)
    ) u_tracker (
        .clk_fpga         (clk_fpga),
        .reset_fpga       (reset_fpga),
        .clear_i          (trk_clear),
        .advance_i        (accept),
        .classifier_idx_o (trk_cls),
        .param_idx_o      (trk_pidx),
        .kind_o           (trk_kind),
        .last_o           (trk_last)
    );

    // NOTE: all state uses non-blocking assignment so every register sees pre-edge values.
    always_ff @(posedge clk_fpga or posedge reset_fpga) begin
        if (reset_fpga) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            rd_en_q <= 1'b0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            abort_q <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            kind_q  <= KIND_PARAM;
            last_q  <= 1'b0;
            cls_q   <= '0;
            pidx_q  <= '0;
        end else begin
            rd_en_q <= 1'b0;
            done_q  <= 1'b0;
            abort_q <= 1'b0;
            // Losing the database mid-stream wins over any in-flight handshake.
            if (abort_now) begin
                state_q <= S_IDLE;
                busy_q  <= 1'b0;
                valid_q <= 1'b0;
                abort_q <= 1'b1;
                addr_q  <= '0;
            end else begin
                unique case (state_q)
                    S_IDLE: begin
                        if (start_ok) begin
                            state_q <= S_FETCH;
                            busy_q  <= 1'b1;
                            rd_en_q <= 1'b1;
                            addr_q  <= '0;
                        end
                    end
                    S_FETCH: state_q <= S_CAPTURE;
                    S_CAPTURE: begin
                        data_q  <= i_rd_data;
                        kind_q  <= trk_kind;
                        cls_q   <= trk_cls;
                        pidx_q  <= trk_pidx;
                        last_q  <= trk_last;
                        valid_q <= 1'b1;
                        state_q <= S_HOLD;
                    end
                    S_HOLD: begin
                        if (accept) begin
                            valid_q <= 1'b0;
                            if (addr_q == LAST_ADDR) begin
                                state_q <= S_DONE;
                                done_q  <= 1'b1;
                            end else begin
                                addr_q  <= addr_q + ADDR_WIDTH'(1);
                                rd_en_q <= 1'b1;
                                state_q <= S_FETCH;
                            end
                        end
                    end
                    S_DONE: begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                        addr_q  <= '0;
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign o_busy    = busy_q;
    assign o_rd_en   = rd_en_q;
    assign o_rd_addr = addr_q;
    assign o_done    = done_q;
    assign o_abort   = abort_q;

    assign param_if.param_valid    = valid_q;
    assign param_if.param_data     = data_q;
    assign param_if.param_kind     = kind_q;
    assign param_if.classifier_idx = cls_q;
    assign param_if.param_idx      = pidx_q;
    assign param_if.param_last     = last_q;

endmodule

// File: tb/tb_stage_database_reader.sv
// Self-checking bench for stage_database_reader: tag vector table, full-stream model
// comparison, random backpressure, abort, async reset and ignored-start sequences.
module tb_stage_database_reader;

    localparam int NCLS  = 10;
    localparam int NPAR  = 19;
    localparam int NTHR  = 3;
    localparam int TOTAL = NCLS * NPAR + NTHR;

    typedef struct packed {
        logic [15:0] data;
        logic        kind;
        logic [3:0]  cls;
        logic [4:0]  idx;
        logic        last;
    } word_t;

    typedef struct {
        int         addr;
        logic       kind;
        logic [3:0] cls;
        logic [4:0] idx;
        logic       last;
    } tag_vec_t;

    logic        clk_fpga;
    logic        reset_fpga;
    logic        i_db_ready;
    logic        i_start;
    logic        o_busy, o_rd_en, o_done, o_abort;
    logic [9:0]  o_rd_addr;
    logic [15:0] i_rd_data;

    stage_database_reader_if #(.DATA_WIDTH(16)) pif ();

    stage_database_reader dut (
        .clk_fpga   (clk_fpga),
        .reset_fpga (reset_fpga),
        .i_db_ready (i_db_ready),
        .i_start    (i_start),
        .o_busy     (o_busy),
        .o_rd_en    (o_rd_en),
        .o_rd_addr  (o_rd_addr),
        .i_rd_data  (i_rd_data),
        .param_if   (pif.master),
        .o_done     (o_done),
        .o_abort    (o_abort)
    );

    int checks   = 0;
    int failures = 0;

    logic [15:0] mem [0:1023];
    int          cyc = 0;
    int          ready_mode = 0;   // 0 high, 1 random 30%, 2 high until stop_n words
    int          stop_n = 0;
    logic        clr_req = 1'b0;
    logic        stab_en = 1'b0;

    word_t got_q[$];
    word_t cur, prev_word;
    logic  prev_stall;
    int    rd_cnt, rd_addr_err, done_cnt, abort_cnt, stall_err;
    int    first_valid_cyc, last_acc_cyc, done_cyc, max_gap;

    assign cur = {pif.param_data, pif.param_kind, pif.classifier_idx, pif.param_idx, pif.param_last};

    initial begin
        clk_fpga = 1'b0;
        forever #5 clk_fpga = ~clk_fpga;
    end

    always @(posedge clk_fpga) cyc <= cyc + 1;

    // Synchronous database memory with one cycle of read latency.
    always @(posedge clk_fpga) if (o_rd_en) i_rd_data <= mem[o_rd_addr];

    initial begin
        pif.param_ready = 1'b0;
        forever begin
            @(posedge clk_fpga);
            #1;
            case (ready_mode)
                0:       pif.param_ready = 1'b1;
                1:       pif.param_ready = ($urandom_range(0, 99) < 30);
                2:       pif.param_ready = (got_q.size() < stop_n);
                default: pif.param_ready = 1'b0;
            endcase
        end
    end

    always @(negedge clk_fpga) begin
        if (clr_req) begin
            got_q.delete();
            rd_cnt          <= 0;
            rd_addr_err     <= 0;
            done_cnt        <= 0;
            abort_cnt       <= 0;
            stall_err       <= 0;
            first_valid_cyc <= -1;
            last_acc_cyc    <= -1;
            done_cyc        <= -1;
            max_gap         <= 0;
            prev_stall      <= 1'b0;
        end else begin
            if (o_rd_en) begin
                if (int'(o_rd_addr) != rd_cnt) rd_addr_err <= rd_addr_err + 1;
                rd_cnt <= rd_cnt + 1;
            end
            if (pif.param_valid && first_valid_cyc < 0) first_valid_cyc <= cyc;
            if (pif.param_valid && pif.param_ready) begin
                got_q.push_back(cur);
                if (last_acc_cyc >= 0 && (cyc - last_acc_cyc) > max_gap) max_gap <= cyc - last_acc_cyc;
                last_acc_cyc <= cyc;
            end
            if (o_done) begin
                done_cnt <= done_cnt + 1;
                done_cyc <= cyc;
            end
            if (o_abort) abort_cnt <= abort_cnt + 1;
            if (stab_en && prev_stall && (!pif.param_valid || cur != prev_word)) stall_err <= stall_err + 1;
            prev_stall <= pif.param_valid && !pif.param_ready;
            prev_word  <= cur;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Reference: tags follow from the address by plain division and remainder.
    function automatic word_t model_word(input int a);
        word_t w;
        w.data = mem[a];
        if (a < NCLS * NPAR) begin
            w.kind = 1'b0;
            w.cls  = 4'(a / NPAR);
            w.idx  = 5'(a % NPAR);
            w.last = ((a % NPAR) == NPAR - 1);
        end else begin
            w.kind = 1'b1;
            w.cls  = 4'd0;
            w.idx  = 5'(a - NCLS * NPAR);
            w.last = (a == TOTAL - 1);
        end
        return w;
    endfunction

    task automatic clear_run();
        @(posedge clk_fpga);
        #1;
        clr_req = 1'b1;
        @(negedge clk_fpga);
        #1;
        clr_req = 1'b0;
    endtask

    task automatic pulse_start(output int t0);
        @(posedge clk_fpga);
        #1;
        i_start = 1'b1;
        @(negedge clk_fpga);
        t0 = cyc;
        @(posedge clk_fpga);
        #1;
        i_start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        int n = 0;
        while (done_cnt == 0 && n < budget) begin
            @(negedge clk_fpga);
            n++;
        end
        check({name, "_done_seen"}, 64'(done_cnt != 0), 64'd1);
        repeat (2) @(negedge clk_fpga);
    endtask

    task automatic check_stream(input string name);
        check({name, "_word_count"}, 64'(got_q.size()), 64'(TOTAL));
        for (int i = 0; i < TOTAL && i < got_q.size(); i++)
            check($sformatf("%s_word%0d", name, i), 64'(got_q[i]), 64'(model_word(i)));
        check({name, "_rd_en_count"}, 64'(rd_cnt), 64'(TOTAL));
        check({name, "_rd_addr_order"}, 64'(rd_addr_err), 64'd0);
        check({name, "_single_done"}, 64'(done_cnt), 64'd1);
        check({name, "_busy_after_done"}, 64'(o_busy), 64'd0);
    endtask

    function automatic logic [63:0] all_outputs();
        return 64'({o_busy, o_rd_en, o_rd_addr, o_done, o_abort, pif.param_valid, pif.param_data,
                    pif.param_kind, pif.classifier_idx, pif.param_idx, pif.param_last});
    endfunction

    tag_vec_t vecs [9];
    int       t0, n;

    initial begin
        vecs[0] = '{0,   1'b0, 4'd0, 5'd0,  1'b0};
        vecs[1] = '{18,  1'b0, 4'd0, 5'd18, 1'b1};
        vecs[2] = '{19,  1'b0, 4'd1, 5'd0,  1'b0};
        vecs[3] = '{37,  1'b0, 4'd1, 5'd18, 1'b1};
        vecs[4] = '{100, 1'b0, 4'd5, 5'd5,  1'b0};
        vecs[5] = '{189, 1'b0, 4'd9, 5'd18, 1'b1};
        vecs[6] = '{190, 1'b1, 4'd0, 5'd0,  1'b0};
        vecs[7] = '{191, 1'b1, 4'd0, 5'd1,  1'b0};
        vecs[8] = '{192, 1'b1, 4'd0, 5'd2,  1'b1};

        for (int a = 0; a < 1024; a++) mem[a] = 16'(a + 16'h100);
        reset_fpga = 1'b1;
        i_db_ready = 1'b1;
        i_start    = 1'b0;
        repeat (3) @(negedge clk_fpga);
        check("reset_outputs", all_outputs(), 64'd0);
        reset_fpga = 1'b0;

        // Full stream with ready tied high: latency, ordering, timing.
        clear_run();
        pulse_start(t0);
        check("t1_busy_after_start", 64'(o_busy), 64'd1);
        wait_done("t1", 2000);
        check("t1_first_valid_latency", 64'(first_valid_cyc - t0), 64'd3);
        check("t1_done_after_last_accept", 64'(done_cyc - last_acc_cyc), 64'd1);
        check("t1_done_cycle", 64'(done_cyc - t0), 64'(3 * TOTAL + 1));
        check("t1_max_gap", 64'(max_gap), 64'd3);
        check_stream("t1");

        // Tag table against the stream just captured.
        foreach (vecs[i]) begin
            if (got_q.size() > vecs[i].addr)
                check($sformatf("t2_tags_addr%0d", vecs[i].addr),
                      64'({got_q[vecs[i].addr].kind, got_q[vecs[i].addr].cls,
                           got_q[vecs[i].addr].idx, got_q[vecs[i].addr].last}),
                      64'({vecs[i].kind, vecs[i].cls, vecs[i].idx, vecs[i].last}));
            else
                check($sformatf("t2_tags_addr%0d_present", vecs[i].addr), 64'(got_q.size()),
                      64'(vecs[i].addr + 1));
        end

        // Random data, random backpressure.
        for (int a = 0; a < TOTAL; a++) mem[a] = 16'($urandom);
        ready_mode = 1;
        stab_en    = 1'b1;
        clear_run();
        pulse_start(t0);
        wait_done("t3", 20000);
        check("t3_stall_stability", 64'(stall_err), 64'd0);
        check_stream("t3");
        stab_en    = 1'b0;
        ready_mode = 0;

        // Database drops mid-stream.
        for (int a = 0; a < 1024; a++) mem[a] = 16'(a + 16'h100);
        clear_run();
        pulse_start(t0);
        n = 0;
        while (got_q.size() < 50 && n < 1000) begin
            @(negedge clk_fpga);
            n++;
        end
        check("t4_reached_word50", 64'(got_q.size() >= 50), 64'd1);
        @(posedge clk_fpga);
        #1;
        i_db_ready = 1'b0;
        @(negedge clk_fpga);
        @(negedge clk_fpga);
        check("t4_abort_pulse", 64'(o_abort), 64'd1);
        check("t4_abort_valid_low", 64'(pif.param_valid), 64'd0);
        check("t4_abort_busy_low", 64'(o_busy), 64'd0);
        @(negedge clk_fpga);
        check("t4_abort_one_cycle", 64'(o_abort), 64'd0);
        check("t4_abort_count", 64'(abort_cnt), 64'd1);
        check("t4_no_done_on_abort", 64'(done_cnt), 64'd0);
        i_db_ready = 1'b1;
        clear_run();
        pulse_start(t0);
        wait_done("t4_restart", 2000);
        check_stream("t4_restart");

        // Async reset while word 100 is held.
        stop_n     = 100;
        ready_mode = 2;
        clear_run();
        pulse_start(t0);
        n = 0;
        while (!(got_q.size() >= 100 && pif.param_valid) && n < 1000) begin
            @(negedge clk_fpga);
            n++;
        end
        check("t5_holding_word100", 64'(pif.param_idx), 64'(model_word(100).idx));
        #2;
        reset_fpga = 1'b1;
        #1;
        check("t5_async_reset_outputs", all_outputs(), 64'd0);
        @(negedge clk_fpga);
        reset_fpga = 1'b0;
        ready_mode = 0;
        clear_run();
        pulse_start(t0);
        wait_done("t5_restart", 2000);
        check_stream("t5_restart");

        // Start without database, then a second start while busy.
        i_db_ready = 1'b0;
        clear_run();
        pulse_start(t0);
        repeat (10) @(negedge clk_fpga);
        check("t6_no_rd_without_db", 64'(rd_cnt), 64'd0);
        check("t6_not_busy_without_db", 64'(o_busy), 64'd0);
        i_db_ready = 1'b1;
        clear_run();
        pulse_start(t0);
        repeat (5) @(posedge clk_fpga);
        pulse_start(t0);
        wait_done("t6", 2000);
        repeat (10) @(negedge clk_fpga);
        check_stream("t6");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
